// File: rtl/sift_pkg.sv
// Shared types and default frame geometry for the UART pixel collector.
package sift_pkg;

  typedef enum logic {
    COLLECT = 1'b0,
    DONE    = 1'b1
  } coll_state_t;

  localparam int DEF_BIT_DEPTH      = 8;
  localparam int DEF_WIDTH          = 64;
  localparam int DEF_HEIGHT         = 64;
  localparam int DEF_TIMEOUT_CYCLES = 50000;

endpackage

// File: rtl/idle_timer.sv
// Idle-gap counter: expire is asserted combinationally on the last idle cycle
// of a TIMEOUT_CYCLES-long gap with no clear while run is high.
module idle_timer
  import sift_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic clear,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] count;

  assign expire = run && !clear && (count == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (!run || clear || expire) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/uart_pixel_collector.sv
// Collects UART bytes into a raster-ordered pixel stream with x/y/addr tags.
// Define COLLECT_TIMEOUT_EN to abort partial frames after an idle gap.
module uart_pixel_collector
  import sift_pkg::*;
#(
  parameter int BIT_DEPTH      = DEF_BIT_DEPTH,
  parameter int WIDTH          = DEF_WIDTH,
  parameter int HEIGHT         = DEF_HEIGHT,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                              clk_in,
  input  logic                              rst_n_in,
  input  logic [BIT_DEPTH-1:0]              data_in,
  input  logic                              data_valid_in,
  input  logic                              rearm_in,
  output logic [BIT_DEPTH-1:0]              data_out,
  output logic [$clog2(WIDTH)-1:0]          data_x_out,
  output logic [$clog2(HEIGHT)-1:0]         data_y_out,
  output logic [$clog2(WIDTH*HEIGHT)-1:0]   data_addr_out,
  output logic                              data_valid_out,
  output logic                              busy_out,
  output logic                              done_out,
  output logic                              timeout_out
);

  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);
  localparam int AW = $clog2(WIDTH * HEIGHT);

  if (WIDTH < 2 || HEIGHT < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("uart_pixel_collector: WIDTH/HEIGHT must be >= 2, TIMEOUT_CYCLES >= 1");
  end

  coll_state_t   state;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [AW-1:0] addr;
  logic          accept;
  logic          last_col;
  logic          last_pixel;
  logic          expire;

  // Rearm outranks an incoming byte; bytes are ignored once the frame is done.
  assign accept     = data_valid_in && !rearm_in && (state == COLLECT);
  assign last_col   = (x == XW'(WIDTH - 1));
  assign last_pixel = last_col && (y == YW'(HEIGHT - 1));
  // A true multiply keeps the address right for non-power-of-two widths.
  assign addr       = AW'(y) * AW'(WIDTH) + AW'(x);

`ifdef COLLECT_TIMEOUT_EN
  idle_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_idle_timer (
    .clk   (clk_in),
    .rst_n (rst_n_in),
    .run   (busy_out),
    .clear (accept || rearm_in),
    .expire(expire)
  );

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      timeout_out <= 1'b0;
    end else begin
      timeout_out <= expire;
    end
  end
`else
  assign expire      = 1'b0;
  assign timeout_out = 1'b0;
`endif

  // NOTE: state is updated only with non-blocking assignments so every
  // right-hand side sees the pre-edge value, regardless of statement order.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state          <= COLLECT;
      x              <= '0;
      y              <= '0;
      data_out       <= '0;
      data_x_out     <= '0;
      data_y_out     <= '0;
      data_addr_out  <= '0;
      data_valid_out <= 1'b0;
      busy_out       <= 1'b0;
      done_out       <= 1'b0;
    end else begin
      data_valid_out <= 1'b0;
      if (rearm_in) begin
        state    <= COLLECT;
        x        <= '0;
        y        <= '0;
        busy_out <= 1'b0;
        done_out <= 1'b0;
      end else if (accept) begin
        data_out       <= data_in;
        data_x_out     <= x;
        data_y_out     <= y;
        data_addr_out  <= addr;
        data_valid_out <= 1'b1;
        if (last_pixel) begin
          state    <= DONE;
          done_out <= 1'b1;
          busy_out <= 1'b0;
        end else begin
          busy_out <= 1'b1;
          if (last_col) begin
            x <= '0;
            y <= y + YW'(1);
          end else begin
            x <= x + XW'(1);
          end
        end
      end else if (expire) begin
        x        <= '0;
        y        <= '0;
        busy_out <= 1'b0;
      end
    end
  end

endmodule
